tf_rom_agu: RTL and testbench
=============================

Name: tf_rom_agu

Overview:
- Twiddle-factor memory with a built-in stage-sequencing address generator for the radix-2, multi-BFU NTT datapath.
- Holds forward and inverse twiddle tables, loaded over a write port. On start, it streams one NUM_BFU-lane twiddle word per accepted cycle, in stage order, to the butterfly array.
- Uses a valid/ready handshake so the datapath can stall it.

Parameters:
- DATA_W, 14, bits per twiddle lane
- NUM_BFU, 4, lanes per memory word (one per butterfly unit)
- LOG_N, 8, log2 of transform length N; number of stages
- WPS, 32, words per stage = N/(2*NUM_BFU)
- ADDR_W, 9, memory address width; must satisfy 2^ADDR_W >= 2*LOG_N*WPS
- DEPTH, 512, memory words = 2*LOG_N*WPS (forward table at 0, inverse table at LOG_N*WPS)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ld_en  in  1  table write strobe
- ld_addr  in  ADDR_W  table write address
- ld_data  in  NUM_BFU*DATA_W  table write data; lane k in bits [k*DATA_W +: DATA_W]
- start  in  1  single-cycle pulse that begins a pass
- inv  in  1  sampled with start; 1 = inverse pass
- tf_q  out  NUM_BFU*DATA_W  twiddle word
- tf_valid  out  1  tf_q is valid
- tf_ready  in  1  consumer accepts tf_q
- tf_stage  out  clog2(LOG_N)  stage index of the word on tf_q
- tf_last  out  1  tf_q is the final word of the pass
- busy  out  1  pass in progress (RUN or DRAIN)
- done  out  1  single-cycle pulse after the final word is accepted

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; counters cleared.
  - tf_q=0, tf_valid=0, tf_stage=0, tf_last=0, busy=0, done=0.
  - Memory contents are not reset.
- Memory: single-port synchronous RAM, one registered read.
  - Read latency is 1 cycle, from read issue to tf_q.
- Load:
  - In IDLE, ld_en=1 writes ld_data to ld_addr on the clock edge.
  - ld_en is ignored in RUN and DRAIN; the memory is unchanged.
  - If ld_en and start are both high in IDLE: the write is performed and start is ignored.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start (with ld_en=0): latch inv; set stage counter s and word counter w to 0.
  - RUN: the read is issued when rd_en = (!tf_valid || tf_ready).
  - Read address:
    - Forward: s*WPS + w.
    - Inverse: LOG_N*WPS + (LOG_N-1-s)*WPS + w, i.e. the stage tables are read in reverse order.
  - On each issued read, w increments. At w=WPS-1, w wraps to 0 and s increments.
  - RUN -> DRAIN when the read with s=LOG_N-1, w=WPS-1 is issued.
  - DRAIN -> IDLE when tf_valid && tf_ready && tf_last. done=1 on the cycle after that acceptance.
- Output register:
  - On an issued read, the following cycle has tf_valid=1.
  - tf_stage = the logical stage s of that read; in inverse mode this is the physical stage LOG_N-1-s.
  - tf_last = 1 only for the final read.
  - When tf_valid && !tf_ready: tf_q, tf_stage, tf_last hold; no read is issued; counters hold.
  - tf_valid clears when the word is accepted and no new read was issued that cycle.
- Throughput: 1 word/cycle with tf_ready held high. A full pass takes LOG_N*WPS words.
  - Latency: start -> first tf_valid = 2 cycles (IDLE->RUN, then read).
- start while busy is ignored.
- busy=1 in RUN and DRAIN.
- rst_n deasserted mid-pass: immediate IDLE, all outputs at their reset values, pass abandoned, no done.

Test Plan:
- Load word i with lane k = (i*4+k) mod 2^14 for i=0..511. Pass start, inv=0, tf_ready=1.
  -> 256 consecutive words, addresses 0..255; tf_stage steps 0..7 every 32 words; tf_last on word 255; done 1 cycle after; first tf_valid 2 cycles after start.
- Same tables, inv=1.
  -> word order: addresses 480..511, then 448..479, ... down to 256..287; tf_last on address 287.
- Forward pass with tf_ready toggled 1,0,0,1 repeating.
  -> no words lost or duplicated; tf_q stable while stalled; total 256 accepted words in order.
- ld_en pulsed to addr 5 with data 0xABC during RUN, then a forward pass.
  -> word 5 still has its original value; start pulses during busy have no effect.
- rst_n low for 1 cycle at word 100 of a pass.
  -> tf_valid=0 and busy=0 immediately, no done. A new start then restarts from address 0.
- ld_en and start high together in IDLE.
  -> write occurs, busy stays 0.

Source files
------------

// File: rtl/tf_rom_agu.sv
// Twiddle-factor memory with a stage-sequencing address generator for a radix-2,
// multi-BFU NTT datapath. Streams one NUM_BFU-lane twiddle word per accepted cycle.
module tf_rom_agu #(
  parameter int unsigned DATA_W  = 14,
  parameter int unsigned NUM_BFU = 4,
  parameter int unsigned LOG_N   = 8,
  parameter int unsigned WPS     = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DEPTH   = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld_en,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [NUM_BFU*DATA_W-1:0]     ld_data,
  input  logic                          start,
  input  logic                          inv,
  output logic [NUM_BFU*DATA_W-1:0]     tf_q,
  output logic                          tf_valid,
  input  logic                          tf_ready,
  output logic [$clog2(LOG_N)-1:0]      tf_stage,
  output logic                          tf_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned WORD_W   = NUM_BFU * DATA_W;
  localparam int unsigned STG_W    = $clog2(LOG_N);
  localparam int unsigned WPS_W    = $clog2(WPS);
  localparam int unsigned INV_BASE = LOG_N * WPS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic                inv_q;
  logic [STG_W-1:0]    s_q;
  logic [WPS_W-1:0]    w_q;
  logic [WORD_W-1:0]   tf_q_q;
  logic                tf_valid_q;
  logic [STG_W-1:0]    tf_stage_q;
  logic                tf_last_q;
  logic                busy_q;
  logic                done_q;

  logic [WORD_W-1:0]   mem [DEPTH];

  logic                rd_en_c;
  logic                last_rd_c;
  logic                ld_wr_c;
  logic [STG_W-1:0]    phys_stage_c;
  logic [ADDR_W-1:0]   rd_addr_c;

  // Read issue and address: the inverse pass walks the stage tables backwards.
  always_comb begin
    rd_en_c      = (state_q == RUN) && (!tf_valid_q || tf_ready);
    last_rd_c    = (s_q == STG_W'(LOG_N - 1)) && (w_q == WPS_W'(WPS - 1));
    ld_wr_c      = (state_q == IDLE) && ld_en;
    phys_stage_c = inv_q ? (STG_W'(LOG_N - 1) - s_q) : s_q;
    rd_addr_c    = ADDR_W'(phys_stage_c) * ADDR_W'(WPS) + ADDR_W'(w_q);
    if (inv_q) begin
      rd_addr_c = rd_addr_c + ADDR_W'(INV_BASE);
    end
  end

  // Table storage is not reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (ld_wr_c) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inv_q      <= 1'b0;
      s_q        <= '0;
      w_q        <= '0;
      tf_q_q     <= '0;
      tf_valid_q <= 1'b0;
      tf_stage_q <= '0;
      tf_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start && !ld_en) begin
            state_q <= RUN;
            inv_q   <= inv;
            s_q     <= '0;
            w_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (rd_en_c) begin
            if (last_rd_c) begin
              state_q <= DRAIN;
            end
            if (w_q == WPS_W'(WPS - 1)) begin
              w_q <= '0;
              s_q <= s_q + 1'b1;
            end else begin
              w_q <= w_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (tf_valid_q && tf_ready && tf_last_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Output skid: hold while stalled, drop valid once the word is taken.
      if (rd_en_c) begin
        tf_q_q     <= mem[rd_addr_c];
        tf_valid_q <= 1'b1;
        tf_stage_q <= s_q;
        tf_last_q  <= last_rd_c;
      end else if (tf_valid_q && tf_ready) begin
        tf_valid_q <= 1'b0;
        tf_last_q  <= 1'b0;
      end
    end
  end

  assign tf_q     = tf_q_q;
  assign tf_valid = tf_valid_q;
  assign tf_stage = tf_stage_q;
  assign tf_last  = tf_last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tf_rom_agu.sv
// Directed, self-checking bench for tf_rom_agu: table of pass configurations plus
// hand-written sequences for load collisions and mid-pass reset.
module tb_tf_rom_agu;

  localparam int unsigned DATA_W  = 14;
  localparam int unsigned NUM_BFU = 4;
  localparam int unsigned LOG_N   = 8;
  localparam int unsigned WPS     = 32;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DEPTH   = 512;
  localparam int unsigned WORD_W  = NUM_BFU * DATA_W;
  localparam int unsigned STG_W   = 3;
  localparam int          NWORDS  = 256;

  logic                clk;
  logic                rst_n;
  logic                ld_en;
  logic [ADDR_W-1:0]   ld_addr;
  logic [WORD_W-1:0]   ld_data;
  logic                start;
  logic                inv;
  logic [WORD_W-1:0]   tf_q;
  logic                tf_valid;
  logic                tf_ready;
  logic [STG_W-1:0]    tf_stage;
  logic                tf_last;
  logic                busy;
  logic                done;

  tf_rom_agu #(
    .DATA_W (DATA_W),
    .NUM_BFU(NUM_BFU),
    .LOG_N  (LOG_N),
    .WPS    (WPS),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .start   (start),
    .inv     (inv),
    .tf_q    (tf_q),
    .tf_valid(tf_valid),
    .tf_ready(tf_ready),
    .tf_stage(tf_stage),
    .tf_last (tf_last),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [WORD_W-1:0] exp_mem [DEPTH];
  logic [WORD_W-1:0] acc_q [NWORDS];
  int                acc_stage [NWORDS];
  logic              acc_last [NWORDS];
  int                n_acc;
  int                first_valid;
  int                last_view;
  int                done_view;
  logic              done_busy;
  int                stall_bad;
  int                busy_bad;

  typedef struct {
    logic inv;
    int   mode;        // 0: ready high, 1: ready 1,0,0,1, 2: ready high + ld/start injected
    int   exp_first;   // view index of first tf_valid (view 0 = just after start is sampled)
    int   exp_last;    // view index at which the last word is accepted
  } pass_vec_t;

  typedef struct {
    logic inv;
    int   idx;
    int   addr;
    int   stage;       // -1: not checked
  } spot_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] model_word(input int i);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < int'(NUM_BFU); k++) begin
      w[k*DATA_W +: DATA_W] = DATA_W'(i * 4 + k);
    end
    return w;
  endfunction

  function automatic int exp_addr(input logic inv_v, input int j);
    if (inv_v) return 256 + (7 - j / 32) * 32 + (j % 32);
    return j;
  endfunction

  task automatic load_all();
    for (int i = 0; i < int'(DEPTH); i++) begin
      ld_en   = 1'b1;
      ld_addr = ADDR_W'(i);
      ld_data = model_word(i);
      exp_mem[i] = model_word(i);
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic run_pass(input logic inv_v, input int mode);
    logic              stall_prev;
    logic [WORD_W-1:0] held;
    stall_prev  = 1'b0;
    held        = '0;
    n_acc       = 0;
    first_valid = -1;
    last_view   = -1;
    done_view   = -1;
    done_busy   = 1'b1;
    stall_bad   = 0;
    busy_bad    = 0;
    inv      = inv_v;
    start    = 1'b1;
    tf_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    inv   = 1'b0;
    for (int c = 0; c < 2000 && done_view < 0; c++) begin
      ld_en = 1'b0;
      start = 1'b0;
      if (mode == 1) tf_ready = ((c % 4) == 0) || ((c % 4) == 3);
      else           tf_ready = 1'b1;
      if (mode == 2 && (c == 10 || c == 40)) begin
        ld_en   = 1'b1;
        ld_addr = ADDR_W'(5);
        ld_data = WORD_W'('hABC);
        start   = 1'b1;
      end
      if (tf_valid && first_valid < 0) first_valid = c;
      if (stall_prev && (!tf_valid || tf_q !== held)) stall_bad++;
      if (!done && busy !== 1'b1) busy_bad++;
      if (tf_valid && tf_ready) begin
        if (n_acc < NWORDS) begin
          acc_q[n_acc]     = tf_q;
          acc_stage[n_acc] = int'(tf_stage);
          acc_last[n_acc]  = tf_last;
        end
        if (tf_last) last_view = c;
        n_acc++;
      end
      stall_prev = tf_valid && !tf_ready;
      held       = tf_q;
      if (done) begin
        done_view = c;
        done_busy = busy;
      end
      @(posedge clk); #1;
    end
    ld_en    = 1'b0;
    start    = 1'b0;
    tf_ready = 1'b1;
    if (done_view < 0) check("pass_timeout", 64'(0), 64'(1));
  endtask

  task automatic verify_pass(input pass_vec_t v);
    int bad_word;
    int bad_stage;
    int bad_last;
    bad_word  = 0;
    bad_stage = 0;
    bad_last  = 0;
    check("word_count", 64'(n_acc), 64'(NWORDS));
    check("first_valid", 64'(first_valid), 64'(v.exp_first));
    check("last_view", 64'(last_view), 64'(v.exp_last));
    check("done_after_last", 64'(done_view), 64'(v.exp_last + 1));
    check("busy_at_done", 64'(done_busy), 64'(0));
    check("busy_in_pass", 64'(busy_bad), 64'(0));
    check("stall_stable", 64'(stall_bad), 64'(0));
    for (int j = 0; j < NWORDS && j < n_acc; j++) begin
      if (acc_q[j] !== exp_mem[exp_addr(v.inv, j)]) bad_word++;
      if (!v.inv && acc_stage[j] != j / 32) bad_stage++;
      if (acc_last[j] !== (j == NWORDS - 1)) bad_last++;
    end
    check("word_order", 64'(bad_word), 64'(0));
    check("stage_seq", 64'(bad_stage), 64'(0));
    check("last_flag", 64'(bad_last), 64'(0));
    // one cycle later: done was a single pulse and the block is idle
    check("done_pulse", 64'(done), 64'(0));
    check("idle_valid", 64'(tf_valid), 64'(0));
  endtask

  pass_vec_t passes [4];
  spot_t     spots [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    passes[0] = '{inv: 1'b0, mode: 0, exp_first: 1, exp_last: 256};
    passes[1] = '{inv: 1'b1, mode: 0, exp_first: 1, exp_last: 256};
    passes[2] = '{inv: 1'b0, mode: 1, exp_first: 1, exp_last: 512};
    passes[3] = '{inv: 1'b0, mode: 2, exp_first: 1, exp_last: 256};
    spots[0] = '{inv: 1'b0, idx: 0,   addr: 0,   stage: 0};
    spots[1] = '{inv: 1'b0, idx: 31,  addr: 31,  stage: 0};
    spots[2] = '{inv: 1'b0, idx: 32,  addr: 32,  stage: 1};
    spots[3] = '{inv: 1'b0, idx: 255, addr: 255, stage: 7};
    spots[4] = '{inv: 1'b1, idx: 0,   addr: 480, stage: -1};
    spots[5] = '{inv: 1'b1, idx: 31,  addr: 511, stage: -1};
    spots[6] = '{inv: 1'b1, idx: 32,  addr: 448, stage: -1};
    spots[7] = '{inv: 1'b1, idx: 255, addr: 287, stage: -1};

    rst_n    = 1'b0;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    start    = 1'b0;
    inv      = 1'b0;
    tf_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tf_q", 64'(tf_q), 64'(0));
    check("rst_valid", 64'(tf_valid), 64'(0));
    check("rst_stage", 64'(tf_stage), 64'(0));
    check("rst_last", 64'(tf_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_all();

    for (int p = 0; p < 4; p++) begin
      run_pass(passes[p].inv, passes[p].mode);
      for (int s = 0; s < 8; s++) begin
        if (spots[s].inv == passes[p].inv) begin
          check($sformatf("spot_word_p%0d_i%0d", p, spots[s].idx),
                64'(acc_q[spots[s].idx]), 64'(model_word(spots[s].addr)));
          if (spots[s].stage >= 0)
            check($sformatf("spot_stage_p%0d_i%0d", p, spots[s].idx),
                  64'(acc_stage[spots[s].idx]), 64'(spots[s].stage));
        end
      end
      verify_pass(passes[p]);
    end

    // ld_en and start together in IDLE: write lands, no pass starts
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(7);
    ld_data = WORD_W'('h1234);
    start   = 1'b1;
    exp_mem[7] = WORD_W'('h1234);
    @(posedge clk); #1;
    ld_en = 1'b0;
    start = 1'b0;
    check("ldstart_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    check("ldstart_busy2", 64'(busy), 64'(0));
    check("ldstart_valid", 64'(tf_valid), 64'(0));

    // mid-pass reset at word 100
    inv   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (101) begin
      @(posedge clk); #1;
    end
    check("pre_rst_valid", 64'(tf_valid), 64'(1));
    check("pre_rst_word", 64'(tf_q), 64'(model_word(100)));
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(tf_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_tf_q", 64'(tf_q), 64'(0));
    check("midrst_last", 64'(tf_last), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("post_rst_quiet", 64'({done, busy, tf_valid}), 64'(0));
      @(posedge clk); #1;
    end

    // fresh forward pass: restarts at address 0, word 5 untouched, word 7 rewritten
    run_pass(1'b0, 0);
    verify_pass(passes[0]);
    check("word5_kept", 64'(acc_q[5]), 64'(model_word(5)));
    check("word7_loaded", 64'(acc_q[7]), 64'(WORD_W'('h1234)));
    check("restart_word0", 64'(acc_q[0]), 64'(model_word(0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
